spi_slave_responder: RTL and testbench
======================================

SPI_SLAVE_RESPONDER -- requirements
Module: spi_slave_responder

Interface
REQ-001 Parameter DATA_W, default 8, frame length in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on every pin input.
REQ-003 PCLK  input  1  system clock; all logic runs on its rising edge.
REQ-004 PRESETn  input  1  reset, asynchronous, active-low.
REQ-005 ss_n  input  1  slave select from the master, active-low, asynchronous to PCLK.
REQ-006 sclk  input  1  serial clock from the master, asynchronous to PCLK.
REQ-007 mosi  input  1  serial data from the master.
REQ-008 spi_mode  input  2  {CPOL,CPHA}, sampled only while ss_n is inactive.
REQ-009 lsbfe  input  1  1 = LSB first, 0 = MSB first, sampled only while ss_n is inactive.
REQ-010 tx_data  input  DATA_W  next word to return to the master.
REQ-011 tx_load  input  1  one-cycle strobe that writes tx_data into the transmit buffer.
REQ-012 rx_read  input  1  one-cycle strobe that acknowledges rx_data.
REQ-013 miso  output  1  serial data to the master.
REQ-014 miso_oe  output  1  MISO output enable, high only while selected.
REQ-015 rx_data  output  DATA_W  last complete received word.
REQ-016 receive_data  output  1  one-cycle pulse when rx_data is updated.
REQ-017 tx_empty  output  1  transmit buffer holds no word.
REQ-018 tip  output  1  transfer in progress.
REQ-019 rx_overrun  output  1  sticky flag: a word completed while rx_full was set.
REQ-020 frame_err  output  1  one-cycle pulse when ss_n is deasserted mid-word.

Function
REQ-021 ss_n, sclk and mosi SHALL each pass through SYNC_STAGES flops; sclk edges are detected by comparing the synced value with its registered copy.
REQ-022 The sample edge SHALL be the rising edge when CPOL==CPHA and the falling edge otherwise; the shift edge SHALL be the opposite edge.
REQ-023 The FSM SHALL have the states IDLE, LOAD, SHIFT and ABORT.
REQ-024 IDLE -> LOAD on synced ss_n falling; LOAD -> SHIFT after 1 cycle; SHIFT -> ABORT on ss_n rising with bit count in 1..DATA_W-1; SHIFT -> IDLE on ss_n rising with bit count 0; ABORT -> IDLE after 1 cycle.
REQ-025 LOAD SHALL copy the transmit buffer into the shift register if tx_empty=0 and set tx_empty=1; otherwise it SHALL load all ones.
REQ-026 With CPHA=0 the first bit SHALL appear on miso in LOAD; with CPHA=1 it SHALL appear on the first shift edge.
REQ-027 Each sample edge SHALL capture mosi and increment a bit counter of width clog2(DATA_W)+1.
REQ-028 When the counter reaches DATA_W: rx_data updated, receive_data pulsed on the next PCLK, counter cleared, shift register reloaded as in LOAD (back-to-back words while ss_n stays low).
REQ-029 rx_full SHALL be set on completion and cleared by rx_read; if a completion and rx_read fall in the same cycle, rx_full stays set.
REQ-030 A completion while rx_full=1 SHALL set rx_overrun and leave rx_data unchanged; rx_overrun clears only on reset.
REQ-031 tx_load SHALL be ignored when tx_empty=0; a tx_load in the same cycle as LOAD's consume SHALL be accepted.
REQ-032 tip SHALL be 1 in LOAD and SHIFT; miso_oe SHALL equal tip; miso SHALL be 0 when miso_oe=0.
REQ-033 ABORT SHALL discard the partial word and pulse frame_err; receive_data SHALL NOT be pulsed.
REQ-034 The sclk half-period SHALL be at least SYNC_STAGES+2 PCLK cycles; behaviour below this bound is undefined.

Reset
REQ-035 On PRESETn low, asynchronously: FSM=IDLE, miso=0, miso_oe=0, tip=0, rx_data=0, receive_data=0, tx_empty=1, rx_full=0, rx_overrun=0, frame_err=0, counters and synchronizers at their inactive levels (ss_n=1, sclk=0).
REQ-036 A reset in the middle of a frame SHALL abort it without pulsing frame_err.

Structure
REQ-037 The FSM state encoding and the mode decode constants SHALL be defined in a shared package spi_pkg.
REQ-038 The synchronizer plus edge detector SHALL be a sub-module spi_sync_edge, instantiated for sclk and ss_n.

Verification
REQ-039 Mode 0, MSB first, tx_load 0xA5, master sends 0x3C -> master receives 0xA5, rx_data=0x3C, one receive_data pulse, tx_empty=1.
REQ-040 Mode 3, LSB first, two back-to-back words 0x81 and 0x7E under one ss_n assertion -> two receive_data pulses with rx_data 0x81 then 0x7E.
REQ-041 No tx_load, mode 1 -> master receives 0xFF.
REQ-042 ss_n released after 5 bits -> frame_err pulses once, no receive_data, rx_data unchanged.
REQ-043 Two words, no rx_read -> rx_overrun=1, rx_data holds the first word.
REQ-044 PRESETn asserted mid-frame -> every output at its reset value in the same cycle, tip=0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave responder: FSM state encoding and
// SPI mode decode ({CPOL,CPHA}) with the sample-edge selection rule.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_ABORT = 2'd3
    } state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t SPI_MODE_RESET = '{cpol: 1'b0, cpha: 1'b0};

    // Data is captured on the rising sclk edge when CPOL==CPHA, else on the falling edge.
    function automatic logic sample_on_rise(input spi_mode_t mode);
        return mode.cpol == mode.cpha;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin plus a change detector that
// compares the synced level with its registered copy.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic sync_o,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: non-blocking assignments so every stage captures its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q[0] <= pin_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign edge_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI slave that returns a buffered word on miso while collecting one word from
// mosi per DATA_W sample edges, all pins oversampled by PCLK.
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              ss_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic [1:0]        spi_mode,
    input  logic              lsbfe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    input  logic              rx_read,
    output logic              miso,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              receive_data,
    output logic              tx_empty,
    output logic              tip,
    output logic              rx_overrun,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    state_e                 state_q;
    spi_mode_t              mode_q;
    logic                   lsbfe_q;
    logic [DATA_W-1:0]      tx_buf_q;
    logic                   tx_empty_q;
    logic [DATA_W-1:0]      tx_sr_q;
    logic [DATA_W-1:0]      rx_sr_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [DATA_W-1:0]      rx_data_q;
    logic                   rx_full_q;
    logic                   rx_overrun_q;
    logic                   receive_data_q;
    logic                   frame_err_q;
    logic                   tip_q;
    logic                   miso_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    logic              ss_sync, ss_edge, sclk_sync, sclk_edge;
    logic              ss_fall, sample_edge, shift_edge;
    logic              word_done, consume, mosi_bit;
    logic [DATA_W-1:0] load_word, rx_next;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .pin_i  (ss_n),
        .sync_o (ss_sync),
        .edge_o (ss_edge)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .pin_i  (sclk),
        .sync_o (sclk_sync),
        .edge_o (sclk_edge)
    );

    function automatic logic tx_bit(input logic [DATA_W-1:0] sr, input logic lsb);
        return lsb ? sr[0] : sr[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] sr, input logic lsb);
        return lsb ? {1'b1, sr[DATA_W-1:1]} : {sr[DATA_W-2:0], 1'b1};
    endfunction

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sample_edge = 1'b0;
        shift_edge  = 1'b0;
        if (sclk_edge) begin
            if (sclk_sync == sample_on_rise(mode_q)) sample_edge = 1'b1;
            else                                     shift_edge  = 1'b1;
        end
    end

    assign ss_fall   = ss_edge & ~ss_sync;
    assign mosi_bit  = mosi_sync_q[SYNC_STAGES-1];
    assign load_word = tx_empty_q ? '1 : tx_buf_q;
    assign rx_next   = lsbfe_q ? {mosi_bit, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], mosi_bit};
    assign word_done = (state_q == ST_SHIFT) && !ss_sync && sample_edge &&
                       (bit_cnt_q == CNT_W'(DATA_W - 1));
    assign consume   = (state_q == ST_LOAD) || word_done;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q        <= ST_IDLE;
            mode_q         <= SPI_MODE_RESET;
            lsbfe_q        <= 1'b0;
            tx_buf_q       <= '0;
            tx_empty_q     <= 1'b1;
            tx_sr_q        <= '0;
            rx_sr_q        <= '0;
            bit_cnt_q      <= '0;
            rx_data_q      <= '0;
            rx_full_q      <= 1'b0;
            rx_overrun_q   <= 1'b0;
            receive_data_q <= 1'b0;
            frame_err_q    <= 1'b0;
            tip_q          <= 1'b0;
            miso_q         <= 1'b0;
            mosi_sync_q    <= '0;
        end else begin
            receive_data_q <= 1'b0;
            frame_err_q    <= 1'b0;
            mosi_sync_q[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                mosi_sync_q[i] <= mosi_sync_q[i-1];
            end

            // Frame format may only change while the master is not selecting us.
            if (ss_sync) begin
                mode_q  <= spi_mode_t'(spi_mode);
                lsbfe_q <= lsbfe;
            end

            // A write coinciding with a consume refills the buffer just emptied.
            if (tx_load && (tx_empty_q || consume)) begin
                tx_buf_q   <= tx_data;
                tx_empty_q <= 1'b0;
            end else if (consume) begin
                tx_empty_q <= 1'b1;
            end

            if (rx_read) rx_full_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    tip_q     <= 1'b0;
                    miso_q    <= 1'b0;
                    bit_cnt_q <= '0;
                    if (ss_fall) begin
                        state_q <= ST_LOAD;
                        tip_q   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_q   <= ST_SHIFT;
                    rx_sr_q   <= '0;
                    bit_cnt_q <= '0;
                    if (mode_q.cpha) begin
                        tx_sr_q <= load_word;
                    end else begin
                        miso_q  <= tx_bit(load_word, lsbfe_q);
                        tx_sr_q <= tx_shift(load_word, lsbfe_q);
                    end
                end
                ST_SHIFT: begin
                    if (ss_sync) begin
                        tip_q   <= 1'b0;
                        miso_q  <= 1'b0;
                        if (bit_cnt_q != '0) begin
                            state_q     <= ST_ABORT;
                            frame_err_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        if (shift_edge) begin
                            miso_q  <= tx_bit(tx_sr_q, lsbfe_q);
                            tx_sr_q <= tx_shift(tx_sr_q, lsbfe_q);
                        end
                        if (word_done) begin
                            bit_cnt_q <= '0;
                            tx_sr_q   <= load_word;
                            rx_full_q <= 1'b1;
                            if (rx_full_q) begin
                                rx_overrun_q <= 1'b1;
                            end else begin
                                rx_data_q      <= rx_next;
                                receive_data_q <= 1'b1;
                            end
                        end else if (sample_edge) begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            rx_sr_q   <= rx_next;
                        end
                    end
                end
                ST_ABORT: begin
                    state_q   <= ST_IDLE;
                    rx_sr_q   <= '0;
                    bit_cnt_q <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign miso         = miso_q;
    assign miso_oe      = tip_q;
    assign tip          = tip_q;
    assign rx_data      = rx_data_q;
    assign receive_data = receive_data_q;
    assign tx_empty     = tx_empty_q;
    assign rx_overrun   = rx_overrun_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: a task-driven SPI master plus a scoreboard of
// expected received words checked whenever receive_data pulses.
module tb_spi_slave_responder;

    localparam int HALF = 8;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       ss_n = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic [1:0] spi_mode = 2'b00;
    logic       lsbfe = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       rx_read = 1'b0;
    logic       miso, miso_oe, receive_data, tx_empty, tip, rx_overrun, frame_err;
    logic [7:0] rx_data;

    int         n_tests = 0;
    int         n_fail = 0;
    int         rd_cnt = 0;
    int         fe_cnt = 0;
    int         rd0, fe0;
    logic [7:0] got;
    logic [7:0] rx_exp_q[$];
    logic       model_full = 1'b0;
    logic       model_overrun = 1'b0;

    spi_slave_responder #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .ss_n         (ss_n),
        .sclk         (sclk),
        .mosi         (mosi),
        .spi_mode     (spi_mode),
        .lsbfe        (lsbfe),
        .tx_data      (tx_data),
        .tx_load      (tx_load),
        .rx_read      (rx_read),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .rx_data      (rx_data),
        .receive_data (receive_data),
        .tx_empty     (tx_empty),
        .tip          (tip),
        .rx_overrun   (rx_overrun),
        .frame_err    (frame_err)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    // Scoreboard: pop one expected word per receive_data pulse.
    always @(negedge PCLK) begin
        if (frame_err) fe_cnt++;
        if (receive_data) begin
            rd_cnt++;
            if (rx_exp_q.size() == 0) check("rx_unexpected_pulse", 32'(receive_data), 32'd0);
            else                      check("rx_data_scoreboard", 32'(rx_data), 32'(rx_exp_q.pop_front()));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic load_tx(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    task automatic ack_rx();
        rx_read = 1'b1;
        tick(1);
        rx_read = 1'b0;
        model_full = 1'b0;
    endtask

    task automatic expect_word(input logic [7:0] w);
        if (!model_full) begin
            rx_exp_q.push_back(w);
            model_full = 1'b1;
        end else begin
            model_overrun = 1'b1;
        end
    endtask

    task automatic select_slave(input logic [1:0] mode, input logic lsb);
        spi_mode = mode;
        lsbfe    = lsb;
        sclk     = mode[1];
        tick(6);
        ss_n = 1'b0;
        tick(HALF);
    endtask

    task automatic deselect_slave();
        tick(HALF);
        ss_n = 1'b1;
        tick(HALF);
    endtask

    task automatic spi_word(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        logic cpol, cpha;
        cpol = spi_mode[1];
        cpha = spi_mode[0];
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx = lsbfe ? i : 7 - i;
            if (!cpha) begin
                mosi = tx[idx];
                tick(HALF);
                sclk = ~cpol;
                rx[idx] = miso;
                tick(HALF);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = tx[idx];
                tick(HALF);
                sclk = cpol;
                rx[idx] = miso;
                tick(HALF);
            end
        end
    endtask

    initial begin
        tick(3);
        check("rst_miso", 32'(miso), 0);
        check("rst_miso_oe", 32'(miso_oe), 0);
        check("rst_tip", 32'(tip), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_receive_data", 32'(receive_data), 0);
        check("rst_tx_empty", 32'(tx_empty), 1);
        check("rst_rx_overrun", 32'(rx_overrun), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        PRESETn = 1'b1;
        tick(4);

        // Mode 0, MSB first: slave returns A5 while receiving 3C.
        load_tx(8'hA5);
        check("m0_tx_empty_loaded", 32'(tx_empty), 0);
        rd0 = rd_cnt;
        expect_word(8'h3C);
        select_slave(2'b00, 1'b0);
        check("m0_tip_selected", 32'(tip), 1);
        check("m0_miso_oe_selected", 32'(miso_oe), 1);
        check("m0_tx_empty_consumed", 32'(tx_empty), 1);
        check("m0_miso_first_bit_in_load", 32'(miso), 1);
        spi_word(8'h3C, 8, got);
        check("m0_master_rx", 32'(got), 32'hA5);
        deselect_slave();
        check("m0_rx_pulses", 32'(rd_cnt - rd0), 1);
        check("m0_rx_data", 32'(rx_data), 32'h3C);
        check("m0_tip_released", 32'(tip), 0);
        check("m0_miso_released", 32'(miso), 0);
        check("m0_tx_empty_end", 32'(tx_empty), 1);
        ack_rx();

        // Mode 3, LSB first, two back-to-back words under one select.
        load_tx(8'h5A);
        rd0 = rd_cnt;
        select_slave(2'b11, 1'b1);
        load_tx(8'hC3);
        expect_word(8'h81);
        spi_word(8'h81, 8, got);
        check("m3_master_rx_w0", 32'(got), 32'h5A);
        ack_rx();
        expect_word(8'h7E);
        spi_word(8'h7E, 8, got);
        check("m3_master_rx_w1", 32'(got), 32'hC3);
        deselect_slave();
        check("m3_rx_pulses", 32'(rd_cnt - rd0), 2);
        check("m3_rx_data", 32'(rx_data), 32'h7E);
        ack_rx();

        // Mode 1 with an empty transmit buffer: master reads all ones.
        expect_word(8'h55);
        select_slave(2'b01, 1'b0);
        spi_word(8'h55, 8, got);
        check("m1_master_rx_empty", 32'(got), 32'hFF);
        deselect_slave();
        check("m1_rx_data", 32'(rx_data), 32'h55);
        ack_rx();

        // Mode 2, select dropped after 5 bits: frame error, no word.
        rd0 = rd_cnt;
        fe0 = fe_cnt;
        select_slave(2'b10, 1'b0);
        spi_word(8'hF0, 5, got);
        deselect_slave();
        check("abort_frame_err_pulses", 32'(fe_cnt - fe0), 1);
        check("abort_rx_pulses", 32'(rd_cnt - rd0), 0);
        check("abort_rx_data_kept", 32'(rx_data), 32'h55);
        check("abort_tip", 32'(tip), 0);

        // Second load while full is ignored; two words without rx_read overrun.
        load_tx(8'h33);
        load_tx(8'h44);
        rd0 = rd_cnt;
        select_slave(2'b00, 1'b0);
        expect_word(8'h11);
        spi_word(8'h11, 8, got);
        check("ovr_master_rx_w0", 32'(got), 32'h33);
        expect_word(8'h22);
        spi_word(8'h22, 8, got);
        check("ovr_master_rx_w1", 32'(got), 32'hFF);
        deselect_slave();
        check("ovr_flag", 32'(rx_overrun), 32'(model_overrun));
        check("ovr_rx_data_first", 32'(rx_data), 32'h11);
        check("ovr_rx_pulses", 32'(rd_cnt - rd0), 1);
        ack_rx();
        tick(2);
        check("ovr_flag_sticky", 32'(rx_overrun), 32'(model_overrun));

        // Reset asserted mid-frame: outputs return to reset values at once.
        load_tx(8'h99);
        fe0 = fe_cnt;
        select_slave(2'b00, 1'b0);
        spi_word(8'h0F, 3, got);
        tick(2);
        check("midrst_tip_before", 32'(tip), 1);
        PRESETn = 1'b0;
        model_full = 1'b0;
        model_overrun = 1'b0;
        #1;
        check("midrst_miso", 32'(miso), 0);
        check("midrst_miso_oe", 32'(miso_oe), 0);
        check("midrst_tip", 32'(tip), 0);
        check("midrst_rx_data", 32'(rx_data), 0);
        check("midrst_receive_data", 32'(receive_data), 0);
        check("midrst_tx_empty", 32'(tx_empty), 1);
        check("midrst_rx_overrun", 32'(rx_overrun), 32'(model_overrun));
        check("midrst_frame_err", 32'(frame_err), 0);
        ss_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        tick(3);
        PRESETn = 1'b1;
        tick(10);
        check("midrst_no_frame_err", 32'(fe_cnt - fe0), 0);
        check("sb_drained", 32'(rx_exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
